// File: rtl/writeback_ctrl_if.sv
// Retire handshake between execute/memory and the writeback controller.
// The producer (master) offers a retiring instruction; the writeback stage
// (slave) answers with ready. A transfer happens when valid && ready.
interface writeback_ctrl_if;
   logic        valid_ixwb_p1;
   logic        ready_wbix_p1;
   logic [2:0]  dest_reg_ixwb_p1;
   logic        reg_write_valid_ixwb_p1;
   logic        load_ixwb_p1;
   logic [15:0] result_ixwb_p1;

   modport master (
      output valid_ixwb_p1,
      output dest_reg_ixwb_p1,
      output reg_write_valid_ixwb_p1,
      output load_ixwb_p1,
      output result_ixwb_p1,
      input  ready_wbix_p1
   );

   modport slave (
      input  valid_ixwb_p1,
      input  dest_reg_ixwb_p1,
      input  reg_write_valid_ixwb_p1,
      input  load_ixwb_p1,
      input  result_ixwb_p1,
      output ready_wbix_p1
   );
endinterface

// File: rtl/writeback_ctrl.sv
// MEM/WB stage controller. It retires one instruction per handshake. Loads
// park in WAIT_LD until the memory response arrives and are written back
// from WB_LD. Every register-file write output comes straight from a flop.
module writeback_ctrl #(
   parameter int LD_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   writeback_ctrl_if.slave   ix,
   input  logic              mem_rd_valid_p1,
   input  logic [15:0]       mem_rd_data_p1,
   output logic [2:0]        dest_reg_index_memwb_p1,
   output logic [15:0]       dest_reg_value_memwb_p1,
   output logic              dest_reg_write_valid_memwb_p1,
   output logic              ld_pending_wbid_p1,
   output logic [2:0]        ld_pending_reg_wbid_p1,
   output logic              ld_timeout_err_p1,
   output logic              spurious_rsp_err_p1,
   output logic [CNT_W-1:0]  retired_cnt_p1
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_LD = 2'd1,
      WB_LD   = 2'd2
   } state_t;

   // The timeout flag is raised on the edge where the wait counter steps
   // from LD_TIMEOUT-1 to LD_TIMEOUT.
   localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(LD_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state_r;
   state_t           state_s;
   logic             accept_s;
   logic [CNT_W-1:0] wait_cnt_r;
   logic             ld_wr_en_r;

   // Next-state decode. Ready depends on the state only, never on valid.
   always_comb begin
      state_s          = state_r;
      ix.ready_wbix_p1 = 1'b1;
      accept_s         = 1'b0;
      case (state_r)
         IDLE, WB_LD: begin
            ix.ready_wbix_p1 = 1'b1;
            accept_s         = ix.valid_ixwb_p1;
            if (ix.valid_ixwb_p1) begin
               if (ix.load_ixwb_p1) begin
                  state_s = WAIT_LD;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT_LD: begin
            ix.ready_wbix_p1 = 1'b0;
            accept_s         = 1'b0;
            if (mem_rd_valid_p1) begin
               state_s = WB_LD;
            end else begin
               state_s = WAIT_LD;
            end
         end
         default: begin
            ix.ready_wbix_p1 = 1'b1;
            accept_s         = 1'b0;
            state_s          = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Write port, load tracking, wait counter, retire counter and sticky errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         dest_reg_index_memwb_p1       <= 3'd0;
         dest_reg_value_memwb_p1       <= 16'd0;
         dest_reg_write_valid_memwb_p1 <= 1'b0;
         ld_pending_wbid_p1            <= 1'b0;
         ld_pending_reg_wbid_p1        <= 3'd0;
         ld_timeout_err_p1             <= 1'b0;
         spurious_rsp_err_p1           <= 1'b0;
         retired_cnt_p1                <= {CNT_W{1'b0}};
         wait_cnt_r                    <= {CNT_W{1'b0}};
         ld_wr_en_r                    <= 1'b0;
      end else begin
         // The write enable is a one-cycle pulse unless refreshed below.
         dest_reg_write_valid_memwb_p1 <= 1'b0;
         if (accept_s) begin
            retired_cnt_p1 <= retired_cnt_p1 + CNT_ONE;
            if (ix.load_ixwb_p1) begin
               ld_pending_wbid_p1     <= 1'b1;
               ld_pending_reg_wbid_p1 <= ix.dest_reg_ixwb_p1;
               ld_wr_en_r             <= ix.reg_write_valid_ixwb_p1;
               wait_cnt_r             <= {CNT_W{1'b0}};
            end else begin
               dest_reg_write_valid_memwb_p1 <= ix.reg_write_valid_ixwb_p1;
               dest_reg_index_memwb_p1       <= ix.dest_reg_ixwb_p1;
               dest_reg_value_memwb_p1       <= ix.result_ixwb_p1;
            end
         end else if (state_r == WAIT_LD) begin
            if (wait_cnt_r != CNT_MAX) begin
               wait_cnt_r <= wait_cnt_r + CNT_ONE;
            end
            if (wait_cnt_r >= TIMEOUT_M1) begin
               ld_timeout_err_p1 <= 1'b1;
            end
            if (mem_rd_valid_p1) begin
               // A load without a register write still completes here.
               dest_reg_write_valid_memwb_p1 <= ld_wr_en_r;
               dest_reg_index_memwb_p1       <= ld_pending_reg_wbid_p1;
               dest_reg_value_memwb_p1       <= mem_rd_data_p1;
               ld_pending_wbid_p1            <= 1'b0;
            end
         end
         if (mem_rd_valid_p1 && (state_r != WAIT_LD)) begin
            spurious_rsp_err_p1 <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Bench for writeback_ctrl: directed stimulus pushes expected register
// writes (index, value, cycle) into a queue; a negedge monitor pops and
// compares whenever the write enable is seen.
module tb_writeback_ctrl;

   localparam int CNT_W = 16;

   typedef struct {
      logic [2:0]  idx;
      logic [15:0] val;
      int          cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_rd_valid_p1;
   logic [15:0]       mem_rd_data_p1;
   logic [2:0]        dest_reg_index_memwb_p1;
   logic [15:0]       dest_reg_value_memwb_p1;
   logic              dest_reg_write_valid_memwb_p1;
   logic              ld_pending_wbid_p1;
   logic [2:0]        ld_pending_reg_wbid_p1;
   logic              ld_timeout_err_p1;
   logic              spurious_rsp_err_p1;
   logic [CNT_W-1:0]  retired_cnt_p1;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t exp_q[$];

   writeback_ctrl_if bus ();

   writeback_ctrl #(.LD_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk                           (clk),
      .rst                           (rst),
      .ix                            (bus.slave),
      .mem_rd_valid_p1               (mem_rd_valid_p1),
      .mem_rd_data_p1                (mem_rd_data_p1),
      .dest_reg_index_memwb_p1       (dest_reg_index_memwb_p1),
      .dest_reg_value_memwb_p1       (dest_reg_value_memwb_p1),
      .dest_reg_write_valid_memwb_p1 (dest_reg_write_valid_memwb_p1),
      .ld_pending_wbid_p1            (ld_pending_wbid_p1),
      .ld_pending_reg_wbid_p1        (ld_pending_reg_wbid_p1),
      .ld_timeout_err_p1             (ld_timeout_err_p1),
      .spurious_rsp_err_p1           (spurious_rsp_err_p1),
      .retired_cnt_p1                (retired_cnt_p1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every observed write must match the oldest expectation.
   always @(negedge clk) begin
      if (dest_reg_write_valid_memwb_p1 === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got idx %0d val 0x%0h, expected no write (cycle %0d)",
                     dest_reg_index_memwb_p1, dest_reg_value_memwb_p1, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_idx", {29'd0, dest_reg_index_memwb_p1}, {29'd0, e.idx});
            check("wr_val", {16'd0, dest_reg_value_memwb_p1}, {16'd0, e.val});
            check("wr_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [2:0] d, input logic rw,
                        input logic ld, input logic [15:0] r);
      bus.valid_ixwb_p1           = v;
      bus.dest_reg_ixwb_p1        = d;
      bus.reg_write_valid_ixwb_p1 = rw;
      bus.load_ixwb_p1            = ld;
      bus.result_ixwb_p1          = r;
   endtask

   task automatic expect_wr(input logic [2:0] d, input logic [15:0] v);
      exp_t e;
      e.idx = d;
      e.val = v;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      mem_rd_valid_p1 = 1'b0;
      mem_rd_data_p1  = 16'h0000;
      drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0000);
      tick();
      tick();
      // Reset state
      check("rst_ready",   {31'd0, bus.ready_wbix_p1}, 32'd1);
      check("rst_wv",      {31'd0, dest_reg_write_valid_memwb_p1}, 32'd0);
      check("rst_idx",     {29'd0, dest_reg_index_memwb_p1}, 32'd0);
      check("rst_val",     {16'd0, dest_reg_value_memwb_p1}, 32'd0);
      check("rst_pend",    {31'd0, ld_pending_wbid_p1}, 32'd0);
      check("rst_preg",    {29'd0, ld_pending_reg_wbid_p1}, 32'd0);
      check("rst_to",      {31'd0, ld_timeout_err_p1}, 32'd0);
      check("rst_sp",      {31'd0, spurious_rsp_err_p1}, 32'd0);
      check("rst_retired", {16'd0, retired_cnt_p1}, 32'd0);
      rst = 1'b0;
      tick();

      // ALU write r3 = 0x1234
      drive(1'b1, 3'd3, 1'b1, 1'b0, 16'h1234);
      expect_wr(3'd3, 16'h1234);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0000);
      check("alu_retired", {16'd0, retired_cnt_p1}, 32'd1);
      tick();
      check("alu_pulse_off", {31'd0, dest_reg_write_valid_memwb_p1}, 32'd0);

      // Non-writing ALU instruction
      drive(1'b1, 3'd6, 1'b0, 1'b0, 16'h5555);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0000);
      check("nowr_wv", {31'd0, dest_reg_write_valid_memwb_p1}, 32'd0);
      check("nowr_retired", {16'd0, retired_cnt_p1}, 32'd2);

      // Spurious response in IDLE
      mem_rd_valid_p1 = 1'b1;
      mem_rd_data_p1  = 16'hDEAD;
      tick();
      mem_rd_valid_p1 = 1'b0;
      check("sp_err", {31'd0, spurious_rsp_err_p1}, 32'd1);
      check("sp_no_wr", {31'd0, dest_reg_write_valid_memwb_p1}, 32'd0);

      do_reset();
      check("sp_cleared", {31'd0, spurious_rsp_err_p1}, 32'd0);
      check("cnt_cleared", {16'd0, retired_cnt_p1}, 32'd0);

      // Load r5, response after 5 cycles of waiting
      drive(1'b1, 3'd5, 1'b1, 1'b1, 16'h0000);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         check("ld_ready", {31'd0, bus.ready_wbix_p1}, 32'd0);
         check("ld_pend", {31'd0, ld_pending_wbid_p1}, 32'd1);
         check("ld_preg", {29'd0, ld_pending_reg_wbid_p1}, 32'd5);
         if (i == 4) begin
            mem_rd_valid_p1 = 1'b1;
            mem_rd_data_p1  = 16'hBEEF;
            expect_wr(3'd5, 16'hBEEF);
         end
         tick();
      end
      mem_rd_valid_p1 = 1'b0;
      check("ld_done_pend", {31'd0, ld_pending_wbid_p1}, 32'd0);
      check("ld_done_ready", {31'd0, bus.ready_wbix_p1}, 32'd1);
      check("ld_sp_clean", {31'd0, spurious_rsp_err_p1}, 32'd0);
      tick();

      // Back-to-back: load r2 then ALU r4 = 0x0007 held while waiting
      drive(1'b1, 3'd2, 1'b1, 1'b1, 16'h0000);
      tick();
      drive(1'b1, 3'd4, 1'b1, 1'b0, 16'h0007);
      tick();
      check("b2b_held", {31'd0, bus.ready_wbix_p1}, 32'd0);
      check("b2b_cnt_hold", {16'd0, retired_cnt_p1}, 32'd2);
      mem_rd_valid_p1 = 1'b1;
      mem_rd_data_p1  = 16'h00AA;
      expect_wr(3'd2, 16'h00AA);
      tick();
      mem_rd_valid_p1 = 1'b0;
      check("b2b_wb_ready", {31'd0, bus.ready_wbix_p1}, 32'd1);
      expect_wr(3'd4, 16'h0007);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0000);
      check("b2b_retired", {16'd0, retired_cnt_p1}, 32'd3);
      tick();
      check("b2b_idle_wv", {31'd0, dest_reg_write_valid_memwb_p1}, 32'd0);

      // Load with no register write still completes
      drive(1'b1, 3'd3, 1'b0, 1'b1, 16'h0000);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0000);
      mem_rd_valid_p1 = 1'b1;
      mem_rd_data_p1  = 16'h7777;
      tick();
      mem_rd_valid_p1 = 1'b0;
      check("ldnw_pend", {31'd0, ld_pending_wbid_p1}, 32'd0);
      check("ldnw_wv", {31'd0, dest_reg_write_valid_memwb_p1}, 32'd0);
      check("ldnw_ready", {31'd0, bus.ready_wbix_p1}, 32'd1);

      do_reset();

      // Timeout with LD_TIMEOUT = 4: response after 10 more cycles
      drive(1'b1, 3'd1, 1'b1, 1'b1, 16'h0000);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0000);
      for (int k = 0; k <= 10; k++) begin
         check("to_err", {31'd0, ld_timeout_err_p1}, (k >= 4) ? 32'd1 : 32'd0);
         if (k == 10) begin
            mem_rd_valid_p1 = 1'b1;
            mem_rd_data_p1  = 16'h0F0F;
            expect_wr(3'd1, 16'h0F0F);
         end
         tick();
      end
      mem_rd_valid_p1 = 1'b0;
      check("to_done_pend", {31'd0, ld_pending_wbid_p1}, 32'd0);
      drive(1'b1, 3'd6, 1'b1, 1'b0, 16'hA5A5);
      expect_wr(3'd6, 16'hA5A5);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0000);
      tick();
      check("to_sticky", {31'd0, ld_timeout_err_p1}, 32'd1);

      do_reset();
      check("to_cleared", {31'd0, ld_timeout_err_p1}, 32'd0);

      // Reset while in WAIT_LD
      drive(1'b1, 3'd7, 1'b1, 1'b1, 16'h0000);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 16'h0000);
      tick();
      check("rw_pend_before", {31'd0, ld_pending_wbid_p1}, 32'd1);
      do_reset();
      check("rw_pend", {31'd0, ld_pending_wbid_p1}, 32'd0);
      check("rw_ready", {31'd0, bus.ready_wbix_p1}, 32'd1);
      check("rw_wv", {31'd0, dest_reg_write_valid_memwb_p1}, 32'd0);
      mem_rd_valid_p1 = 1'b1;
      mem_rd_data_p1  = 16'h1111;
      tick();
      mem_rd_valid_p1 = 1'b0;
      check("rw_late_sp", {31'd0, spurious_rsp_err_p1}, 32'd1);
      check("rw_late_wv", {31'd0, dest_reg_write_valid_memwb_p1}, 32'd0);
      tick();
      tick();

      check("sb_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/writeback_ctrl.md
Name: writeback_ctrl

Overview:
- MEM/WB stage controller that drives the register-file write port consumed by decode: dest_reg_index_memwb_p1, dest_reg_value_memwb_p1, dest_reg_write_valid_memwb_p1.
- Accepts retiring results from execute/memory over a valid/ready handshake.
- Waits on multi-cycle load responses, then issues exactly one register write per retiring instruction.
- Exports load-pending status so decode can stall on load-use hazards.

Parameters:
- LD_TIMEOUT, 64, max cycles allowed in WAIT_LD before a timeout error is flagged; legal range 2..65535.
- CNT_W, 16, width of the load wait counter and the retired-instruction counter.

Ports:
- clk  in  1  clock, single domain
- rst  in  1  synchronous, active-high reset
- valid_ixwb_p1  in  1  retiring instruction valid
- ready_wbix_p1  out  1  stage can accept; handshake completes when valid&&ready
- dest_reg_ixwb_p1  in  3  destination register index
- reg_write_valid_ixwb_p1  in  1  instruction writes a register
- load_ixwb_p1  in  1  value comes from memory read response, not result
- result_ixwb_p1  in  16  ALU/EA result (store-with-update writes EA via this path)
- mem_rd_valid_p1  in  1  load data response strobe, one cycle
- mem_rd_data_p1  in  16  load data
- dest_reg_index_memwb_p1  out  3  register-file write index
- dest_reg_value_memwb_p1  out  16  register-file write data
- dest_reg_write_valid_memwb_p1  out  1  register-file write enable, one-cycle pulse
- ld_pending_wbid_p1  out  1  load accepted, data not yet written
- ld_pending_reg_wbid_p1  out  3  destination of the pending load
- ld_timeout_err_p1  out  1  sticky: load wait exceeded LD_TIMEOUT
- spurious_rsp_err_p1  out  1  sticky: mem_rd_valid_p1 seen while not in WAIT_LD
- retired_cnt_p1  out  CNT_W  count of accepted instructions, wraps at 2^CNT_W

Behaviour:
- FSM states: IDLE, WAIT_LD, WB_LD. Reset -> IDLE.
- Reset values:
  - all outputs 0, except ready_wbix_p1 = 1.
  - internal wait counter 0.
  - sticky errors clear only on rst.
- ready_wbix_p1:
  - 1 in IDLE and WB_LD.
  - 0 in WAIT_LD.
  - Combinational from state only; it never depends on valid_ixwb_p1.
- Accept, non-load (state IDLE or WB_LD):
  - Register index/result.
  - dest_reg_write_valid_memwb_p1 = reg_write_valid_ixwb_p1 on the next cycle, so latency is 1.
  - Write valid 0 when the instruction does not write.
  - State -> IDLE.
- Accept, load:
  - Capture dest index; state -> WAIT_LD.
  - ld_pending_wbid_p1 = 1 and ld_pending_reg_wbid_p1 = index, both from the next cycle.
  - Wait counter cleared.
  - The load does not write a register unless reg_write_valid_ixwb_p1 = 1. When 0, data is discarded and the load still completes.
- WAIT_LD:
  - Counter increments each cycle, saturating at the maximum.
  - When mem_rd_valid_p1 = 1: capture data; state -> WB_LD.
  - In WB_LD, dest_reg_write_valid_memwb_p1 = 1 (if enabled) with that data, and ld_pending_wbid_p1 drops to 0 that same cycle.
  - Load-to-write latency: 1 cycle after the response.
- Load response and new instruction in the same cycle:
  - A response in the same cycle as valid_ixwb_p1 is legal; ready is 0, so the new instruction is held.
  - In WB_LD a new instruction may be accepted in the same cycle as the load write. Its own write occurs the following cycle, so back-to-back writes never collide.
- Timeout: when the counter reaches LD_TIMEOUT in WAIT_LD, set ld_timeout_err_p1 and remain in WAIT_LD. A later response still completes normally.
- mem_rd_valid_p1 in IDLE or WB_LD: ignored for data, sets spurious_rsp_err_p1.
- Write-valid pulse: dest_reg_write_valid_memwb_p1 is exactly one cycle per write and is never asserted on consecutive cycles for the same instruction.
- retired_cnt_p1: increments on every accepted handshake, load or not; wraps from all-ones to 0.
- Reset mid-operation (including WAIT_LD): no write is issued, pending cleared, state IDLE the next cycle, counter 0.
- No combinational path from valid_ixwb_p1 or mem_rd_* to any write output; all write outputs are registered.

Test Plan:
- ALU write: valid=1, dest=3, result=0x1234, rw=1 -> next cycle write_valid=1, index=3, value=0x1234; the cycle after, write_valid=0; retired_cnt=1.
- Load, 5-cycle memory:
  - Accept load dest=5 -> ready=0 and ld_pending=1/reg=5 for 5 cycles.
  - mem_rd_valid with 0xBEEF -> next cycle write index 5 = 0xBEEF, ld_pending=0, ready=1.
- Back-to-back: load(r2) then ALU(r4, 0x0007) presented continuously.
  - r2 write in WB_LD cycle; r4 write the next cycle.
  - Never two writes in one cycle; retired_cnt=2.
- Timeout with LD_TIMEOUT=4: response held off 10 cycles -> ld_timeout_err=1 from cycle 4; data still written at cycle 11; error stays 1 until rst.
- Spurious response: mem_rd_valid=1 in IDLE -> no write, spurious_rsp_err=1.
- Reset in WAIT_LD: assert rst one cycle -> ld_pending=0, ready=1, no write; a later response only sets spurious_rsp_err.
